// File: rtl/nv_nvdla_cdma_wt_rd_sched.sv
// nv_nvdla_cdma_wt_rd_sched
// Weight-path DMA read-request scheduler. Arbitrates the weight, WMB and WGS
// fetch requesters onto one registered DMA read-request slot. Each grant is
// gated by a credit counter tracking free read-return latency-FIFO entries.
//
// Ports:
//   nvdla_core_clk / nvdla_core_rstn   clock, synchronous active-low reset
//   {wt,wmb,wgs}_req_{valid,addr,size} requester inputs (size = atoms - 1)
//   {wt,wmb,wgs}_req_ready             combinational grant, one-hot or zero
//   dma_rd_req_{pvld,pd,src}           registered output slot, pd = {size, addr}
//   dma_rd_req_prdy                    downstream accept
//   credit_ret                         one latency-FIFO entry freed
//   credit_cnt                         free credits (registered)
//   sched_idle                         slot empty and all credits home
//
// Optional feature: define NVDLA_CDMA_WT_STARVE_GUARD_EN to add per-requester
// starvation counters that promote wmb/wgs above wt after STARVE_LIM cycles.
module nv_nvdla_cdma_wt_rd_sched #(
   parameter int unsigned ADDR_W     = 64,
   parameter int unsigned SIZE_W     = 15,
   parameter int unsigned CREDIT_MAX = 128,
   parameter int unsigned CREDIT_W   = 8,
   parameter int unsigned STARVE_LIM = 16
) (
   input  logic                       nvdla_core_clk,
   input  logic                       nvdla_core_rstn,
   input  logic                       wt_req_valid,
   input  logic                       wmb_req_valid,
   input  logic                       wgs_req_valid,
   output logic                       wt_req_ready,
   output logic                       wmb_req_ready,
   output logic                       wgs_req_ready,
   input  logic [ADDR_W-1:0]          wt_req_addr,
   input  logic [ADDR_W-1:0]          wmb_req_addr,
   input  logic [ADDR_W-1:0]          wgs_req_addr,
   input  logic [SIZE_W-1:0]          wt_req_size,
   input  logic [SIZE_W-1:0]          wmb_req_size,
   input  logic [SIZE_W-1:0]          wgs_req_size,
   output logic                       dma_rd_req_pvld,
   input  logic                       dma_rd_req_prdy,
   output logic [ADDR_W+SIZE_W-1:0]   dma_rd_req_pd,
   output logic [1:0]                 dma_rd_req_src,
   input  logic                       credit_ret,
   output logic [CREDIT_W-1:0]        credit_cnt,
   output logic                       sched_idle
);

   localparam int unsigned PD_W  = ADDR_W + SIZE_W;
   // wide enough for size+1 and for credit_cnt+1 without overflow
   localparam int unsigned CMP_W = ((SIZE_W + 1) > (CREDIT_W + 1)) ? (SIZE_W + 1) : (CREDIT_W + 1);
   localparam logic [1:0]  SRC_WT  = 2'd0;
   localparam logic [1:0]  SRC_WMB = 2'd1;
   localparam logic [1:0]  SRC_WGS = 2'd2;

   logic                pvld_q, pvld_d;
   logic [PD_W-1:0]     pd_q, pd_d;
   logic [1:0]          src_q, src_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic                idle_q, idle_d;

   logic [CMP_W-1:0]    credit_x, wt_need, wmb_need, wgs_need, grant_need, credit_sum;
   logic                wt_elig, wmb_elig, wgs_elig;
   logic                slot_open;
   logic                gnt_wt, gnt_wmb, gnt_wgs;
   logic                wmb_promote, wgs_promote;

   // Eligibility against registered credits only
   always_comb begin
      credit_x  = CMP_W'(credit_q);
      wt_need   = CMP_W'(wt_req_size)  + CMP_W'(1);
      wmb_need  = CMP_W'(wmb_req_size) + CMP_W'(1);
      wgs_need  = CMP_W'(wgs_req_size) + CMP_W'(1);
      wt_elig   = wt_req_valid  && (credit_x >= wt_need);
      wmb_elig  = wmb_req_valid && (credit_x >= wmb_need);
      wgs_elig  = wgs_req_valid && (credit_x >= wgs_need);
      slot_open = !pvld_q || dma_rd_req_prdy;
   end

`ifdef NVDLA_CDMA_WT_STARVE_GUARD_EN
   localparam int unsigned SC_W = $clog2(STARVE_LIM + 1);

   logic [SC_W-1:0] wmb_starve_q, wmb_starve_d;
   logic [SC_W-1:0] wgs_starve_q, wgs_starve_d;

   // Count eligible-but-not-granted cycles, saturate, clear on grant or valid drop
   always_comb begin
      wmb_starve_d = wmb_starve_q;
      wgs_starve_d = wgs_starve_q;
      if (!wmb_req_valid || gnt_wmb)
         wmb_starve_d = '0;
      else if (wmb_elig && (wmb_starve_q != SC_W'(STARVE_LIM)))
         wmb_starve_d = wmb_starve_q + SC_W'(1);
      if (!wgs_req_valid || gnt_wgs)
         wgs_starve_d = '0;
      else if (wgs_elig && (wgs_starve_q != SC_W'(STARVE_LIM)))
         wgs_starve_d = wgs_starve_q + SC_W'(1);
      wmb_promote = wmb_elig && (wmb_starve_q == SC_W'(STARVE_LIM));
      wgs_promote = wgs_elig && (wgs_starve_q == SC_W'(STARVE_LIM));
   end

   always_ff @(posedge nvdla_core_clk) begin
      if (!nvdla_core_rstn) begin
         wmb_starve_q <= '0;
         wgs_starve_q <= '0;
      end else begin
         wmb_starve_q <= wmb_starve_d;
         wgs_starve_q <= wgs_starve_d;
      end
   end
`else
   always_comb begin
      wmb_promote = 1'b0;
      wgs_promote = 1'b0;
   end
`endif

   // Fixed priority wt > wmb > wgs, with starved requesters (wmb first) on top
   always_comb begin
      gnt_wt  = 1'b0;
      gnt_wmb = 1'b0;
      gnt_wgs = 1'b0;
      if (nvdla_core_rstn && slot_open) begin
         if (wmb_promote)      gnt_wmb = 1'b1;
         else if (wgs_promote) gnt_wgs = 1'b1;
         else if (wt_elig)     gnt_wt  = 1'b1;
         else if (wmb_elig)    gnt_wmb = 1'b1;
         else if (wgs_elig)    gnt_wgs = 1'b1;
      end
   end

   // Slot load, credit update and idle flag
   always_comb begin
      pvld_d     = pvld_q;
      pd_d       = pd_q;
      src_d      = src_q;
      grant_need = '0;
      if (slot_open)
         pvld_d = 1'b0;
      if (gnt_wt) begin
         pvld_d     = 1'b1;
         pd_d       = {wt_req_size, wt_req_addr};
         src_d      = SRC_WT;
         grant_need = wt_need;
      end else if (gnt_wmb) begin
         pvld_d     = 1'b1;
         pd_d       = {wmb_req_size, wmb_req_addr};
         src_d      = SRC_WMB;
         grant_need = wmb_need;
      end else if (gnt_wgs) begin
         pvld_d     = 1'b1;
         pd_d       = {wgs_req_size, wgs_req_addr};
         src_d      = SRC_WGS;
         grant_need = wgs_need;
      end
      // grant implies credit_x >= grant_need, so only the upper bound needs clamping
      credit_sum = credit_x - grant_need + CMP_W'(credit_ret);
      credit_d   = (credit_sum > CMP_W'(CREDIT_MAX)) ? CREDIT_W'(CREDIT_MAX) : CREDIT_W'(credit_sum);
      idle_d     = !pvld_d && (credit_d == CREDIT_W'(CREDIT_MAX));
   end

   always_ff @(posedge nvdla_core_clk) begin
      if (!nvdla_core_rstn) begin
         pvld_q   <= 1'b0;
         pd_q     <= '0;
         src_q    <= SRC_WT;
         credit_q <= CREDIT_W'(CREDIT_MAX);
         idle_q   <= 1'b1;
      end else begin
         pvld_q   <= pvld_d;
         pd_q     <= pd_d;
         src_q    <= src_d;
         credit_q <= credit_d;
         idle_q   <= idle_d;
      end
   end

   assign wt_req_ready    = gnt_wt;
   assign wmb_req_ready   = gnt_wmb;
   assign wgs_req_ready   = gnt_wgs;
   assign dma_rd_req_pvld = pvld_q;
   assign dma_rd_req_pd   = pd_q;
   assign dma_rd_req_src  = src_q;
   assign credit_cnt      = credit_q;
   assign sched_idle      = idle_q;

   // A request larger than the whole latency FIFO can never be granted
   a_wt_size_legal  : assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
                                       wt_req_valid  |-> (wt_need  <= CMP_W'(CREDIT_MAX)));
   a_wmb_size_legal : assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
                                       wmb_req_valid |-> (wmb_need <= CMP_W'(CREDIT_MAX)));
   a_wgs_size_legal : assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
                                       wgs_req_valid |-> (wgs_need <= CMP_W'(CREDIT_MAX)));
   a_param_sane     : assert property (@(posedge nvdla_core_clk)
                                       (CREDIT_MAX < (2 ** CREDIT_W)) && (STARVE_LIM > 0));

endmodule

// File: tb/tb_nv_nvdla_cdma_wt_rd_sched.sv
// Directed bench for nv_nvdla_cdma_wt_rd_sched. Expected output-slot contents
// are queued when a grant is issued; a negedge monitor pops and compares them
// on every output handshake. Ready/credit/idle are checked inline.
module tb_nv_nvdla_cdma_wt_rd_sched;

   localparam int unsigned ADDR_W   = 64;
   localparam int unsigned SIZE_W   = 15;
   localparam int unsigned PD_W     = ADDR_W + SIZE_W;
   localparam int unsigned CREDIT_W = 8;
`ifdef NVDLA_CDMA_WT_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rstn;
   logic                wt_v, wmb_v, wgs_v;
   logic                wt_r, wmb_r, wgs_r;
   logic [ADDR_W-1:0]   wt_a, wmb_a, wgs_a;
   logic [SIZE_W-1:0]   wt_s, wmb_s, wgs_s;
   logic                pvld, prdy;
   logic [PD_W-1:0]     pd;
   logic [1:0]          src;
   logic                cret;
   logic [CREDIT_W-1:0] ccnt;
   logic                idle;

   nv_nvdla_cdma_wt_rd_sched dut (
      .nvdla_core_clk  (clk),
      .nvdla_core_rstn (rstn),
      .wt_req_valid    (wt_v),
      .wmb_req_valid   (wmb_v),
      .wgs_req_valid   (wgs_v),
      .wt_req_ready    (wt_r),
      .wmb_req_ready   (wmb_r),
      .wgs_req_ready   (wgs_r),
      .wt_req_addr     (wt_a),
      .wmb_req_addr    (wmb_a),
      .wgs_req_addr    (wgs_a),
      .wt_req_size     (wt_s),
      .wmb_req_size    (wmb_s),
      .wgs_req_size    (wgs_s),
      .dma_rd_req_pvld (pvld),
      .dma_rd_req_prdy (prdy),
      .dma_rd_req_pd   (pd),
      .dma_rd_req_src  (src),
      .credit_ret      (cret),
      .credit_cnt      (ccnt),
      .sched_idle      (idle)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [1:0]      src;
      logic [PD_W-1:0] pd;
   } exp_t;
   exp_t exp_q[$];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic expect_out(input logic [1:0] s, input logic [SIZE_W-1:0] sz, input logic [ADDR_W-1:0] a);
      exp_t e;
      e.src = s;
      e.pd  = {sz, a};
      exp_q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Output monitor: every accepted slot must match the next queued expectation
   always @(negedge clk) begin
      exp_t e;
      if (rstn && pvld && prdy) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got src=%0d pd=%0h, none expected", src, pd);
         end else begin
            e = exp_q.pop_front();
            chk("out_pd", 128'(pd), 128'(e.pd));
            chk("out_src", 128'(src), 128'(e.src));
         end
      end
   end

   initial begin
      logic [ADDR_W-1:0] a;
      logic [PD_W-1:0]   pdx;
      bit                exp_wgs;

      rstn = 1'b0;
      wt_v = 1'b1; wmb_v = 1'b0; wgs_v = 1'b0;
      wt_a = '0; wmb_a = '0; wgs_a = '0;
      wt_s = '0; wmb_s = '0; wgs_s = '0;
      prdy = 1'b1; cret = 1'b0;
      #2;
      chk("rst_no_grant", 128'(wt_r), 128'd0);
      step();
      step();
      rstn = 1'b1;
      wt_v = 1'b0;
      #1;
      chk("rst_pvld", 128'(pvld), 128'd0);
      chk("rst_pd", 128'(pd), 128'd0);
      chk("rst_src", 128'(src), 128'd0);
      chk("rst_credit", 128'(ccnt), 128'd128);
      chk("rst_idle", 128'(idle), 128'd1);

      // All three requesting size 0: wt wins each cycle, credits stay full
      wt_v = 1'b1; wmb_v = 1'b1; wgs_v = 1'b1;
      wmb_a = 64'h2000; wgs_a = 64'h3000;
      cret = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wt_a = 64'h1000 + 64'(i) * 64'h20;
         #1;
         chk("prio_wt_ready", 128'(wt_r), 128'd1);
         chk("prio_wmb_ready", 128'(wmb_r), 128'd0);
         chk("prio_wgs_ready", 128'(wgs_r), 128'd0);
         chk("prio_credit", 128'(ccnt), 128'd128);
         expect_out(2'd0, 15'd0, wt_a);
         step();
      end
      wt_v = 1'b0; wmb_v = 1'b0; wgs_v = 1'b0; cret = 1'b0;
      #1;
      chk("prio_last_pvld", 128'(pvld), 128'd1);
      step();
      step();
      chk("prio_idle", 128'(idle), 128'd1);
      chk("prio_credit_end", 128'(ccnt), 128'd128);

      // Credit exhaustion: 2 x 64 atoms drain all 128 credits
      wt_v = 1'b1; wt_s = 15'd63; wt_a = 64'hA000;
      #1;
      chk("cx_ready1", 128'(wt_r), 128'd1);
      expect_out(2'd0, 15'd63, 64'hA000);
      step();
      wt_a = 64'hA800;
      #1;
      chk("cx_credit64", 128'(ccnt), 128'd64);
      chk("cx_ready2", 128'(wt_r), 128'd1);
      expect_out(2'd0, 15'd63, 64'hA800);
      step();
      chk("cx_credit0", 128'(ccnt), 128'd0);
      chk("cx_stall", 128'(wt_r), 128'd0);
      step();
      chk("cx_stall2", 128'(wt_r), 128'd0);
      wt_v = 1'b0;
      cret = 1'b1;
      repeat (4) step();
      cret = 1'b0;
      chk("cx_credit4", 128'(ccnt), 128'd4);
      wmb_v = 1'b1; wmb_s = 15'd3; wmb_a = 64'hB000;
      #1;
      chk("cx_wmb_ready", 128'(wmb_r), 128'd1);
      chk("cx_wt_ready", 128'(wt_r), 128'd0);
      expect_out(2'd1, 15'd3, 64'hB000);
      step();
      wmb_v = 1'b0;
      chk("cx_credit_wmb", 128'(ccnt), 128'd0);
      // refill past the maximum to exercise the upper clamp
      cret = 1'b1;
      repeat (130) step();
      cret = 1'b0;
      chk("cx_credit_clamp", 128'(ccnt), 128'd128);
      chk("cx_idle", 128'(idle), 128'd1);

      // Back-pressure: slot holds while prdy is low
      prdy = 1'b0;
      wt_v = 1'b1; wt_s = 15'd1; wt_a = 64'hC000;
      #1;
      chk("bp_first_ready", 128'(wt_r), 128'd1);
      expect_out(2'd0, 15'd1, 64'hC000);
      step();
      wt_a = 64'hC040;
      a = 64'hC000;
      pdx = {15'd1, a};
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_ready_low", 128'(wt_r), 128'd0);
         chk("bp_pvld_hold", 128'(pvld), 128'd1);
         chk("bp_pd_hold", 128'(pd), 128'(pdx));
         step();
      end
      prdy = 1'b1;
      #1;
      chk("bp_release_ready", 128'(wt_r), 128'd1);
      expect_out(2'd0, 15'd1, 64'hC040);
      step();
      wt_v = 1'b0;
      a = 64'hC040;
      pdx = {15'd1, a};
      #1;
      chk("bp_second_pd", 128'(pd), 128'(pdx));
      chk("bp_credit", 128'(ccnt), 128'd124);
      step();
      step();

      // wt and wgs contend; the guard (if built) promotes wgs after 16 losses
      wt_v = 1'b1; wt_s = 15'd0; wt_a = 64'hD000;
      wgs_v = 1'b1; wgs_s = 15'd0; wgs_a = 64'hE000;
      for (int i = 0; i < 20; i++) begin
         exp_wgs = GUARD && (i == 16);
         #1;
         chk("sv_wt_ready", 128'(wt_r), 128'(!exp_wgs));
         chk("sv_wgs_ready", 128'(wgs_r), 128'(exp_wgs));
         if (exp_wgs) expect_out(2'd2, 15'd0, 64'hE000);
         else         expect_out(2'd0, 15'd0, 64'hD000);
         step();
      end
      wt_v = 1'b0; wgs_v = 1'b0;
      step();
      step();
      chk("sv_credit", 128'(ccnt), 128'd104);

      // Mid-operation reset drops the pending slot and restores credits
      prdy = 1'b0;
      wt_v = 1'b1; wt_s = 15'd63; wt_a = 64'hF000;
      #1;
      chk("mr_ready", 128'(wt_r), 128'd1);
      step();
      wt_v = 1'b0;
      #1;
      chk("mr_pvld", 128'(pvld), 128'd1);
      chk("mr_credit40", 128'(ccnt), 128'd40);
      chk("mr_busy", 128'(idle), 128'd0);
      rstn = 1'b0;
      wt_v = 1'b1; wt_s = 15'd0;
      #1;
      chk("mr_no_grant", 128'(wt_r), 128'd0);
      step();
      rstn = 1'b1;
      wt_v = 1'b0;
      #1;
      chk("mr_pvld_clr", 128'(pvld), 128'd0);
      chk("mr_credit", 128'(ccnt), 128'd128);
      chk("mr_idle", 128'(idle), 128'd1);
      chk("mr_pd", 128'(pd), 128'd0);

      prdy = 1'b1;
      repeat (3) step();
      chk("queue_drained", 128'(exp_q.size()), 128'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/nv_nvdla_cdma_wt_rd_sched.md
# nv_nvdla_cdma_wt_rd_sched

CDMA weight-path DMA read-request scheduler. It shares the single weight read-request port among three fetch requesters: weight data, WMB (sparse mask) and WGS (group size). Grants follow fixed priority with an optional starvation guard. Each grant is gated by a credit counter that mirrors free entries in the downstream read-return latency FIFO. The block sits between the weight fetch address generators and the CDMA DMA read mux, and registers the selected request onto the DMA port.

## Interface
Parameters:
- ADDR_W, 64, request address width in bytes.
- SIZE_W, 15, request size field width; the field holds the atom count minus 1 (32-byte atoms).
- CREDIT_MAX, 128, number of latency-FIFO entries, in atoms.
- CREDIT_W, 8, credit counter width; must hold CREDIT_MAX.
- STARVE_LIM, 16, number of waiting cycles before a low-priority requester is promoted.

Ports:
- nvdla_core_clk  in  1  core clock.
- nvdla_core_rstn  in  1  reset; synchronous, active-low.
- wt_req_valid / wmb_req_valid / wgs_req_valid  in  1 each  request valid, one per requester.
- wt_req_ready / wmb_req_ready / wgs_req_ready  out  1 each  request accepted this cycle.
- wt_req_addr / wmb_req_addr / wgs_req_addr  in  ADDR_W each  byte address.
- wt_req_size / wmb_req_size / wgs_req_size  in  SIZE_W each  atoms minus 1.
- dma_rd_req_pvld  out  1  output request valid.
- dma_rd_req_prdy  in  1  downstream accept.
- dma_rd_req_pd  out  ADDR_W+SIZE_W  {size, addr}.
- dma_rd_req_src  out  2  source tag: 0 = wt, 1 = wmb, 2 = wgs.
- credit_ret  in  1  one latency-FIFO entry freed this cycle.
- credit_cnt  out  CREDIT_W  current free credits.
- sched_idle  out  1  high when no output is pending and credit_cnt == CREDIT_MAX.

## Operation
- Output slot: a single register (pvld, pd, src). The slot is "open" when !pvld or (pvld && prdy).
- Eligibility: a requester is eligible when its valid is high and credit_cnt >= size+1. The comparison uses the registered credit_cnt only; a same-cycle credit_ret is not counted.
- Grant: at most one grant per cycle, and only when the slot is open. ready is combinational and is high for the granted requester only.
- Base priority: wt > wmb > wgs. An ineligible higher-priority requester does not block an eligible lower-priority one.
- Credit update: credit_cnt_next = credit_cnt - (grant ? size+1 : 0) + credit_ret. It must never exceed CREDIT_MAX or go below 0. A request with size+1 > CREDIT_MAX is illegal and is flagged by an assertion.
- Slot load: on grant the slot loads {size, addr} and the source tag. If the slot is open and there is no grant, pvld clears.
- Requester inputs must stay stable while valid is high and ready is low. The block does not check this.

## Timing
- Reset values: dma_rd_req_pvld = 0, dma_rd_req_pd = 0, dma_rd_req_src = 0, all ready = 0 (combinational; no valid is granted during reset), credit_cnt = CREDIT_MAX, starvation counters = 0, sched_idle = 1.
- Latency: a handshake in cycle N produces dma_rd_req_pvld in cycle N+1. With prdy held high, the port sustains one request per cycle.
- Back-pressure: while pvld && !prdy, all ready signals are 0 and pd/src hold stable.
- Simultaneous grant and credit_ret: both are applied in the same cycle, with net change -(size+1)+1.
- Reset asserted mid-operation: the pending output is dropped, credits return to CREDIT_MAX, and no grant occurs during the reset cycle.

## Configuration
- NVDLA_CDMA_WT_STARVE_GUARD_EN defined:
  - wmb and wgs each have a counter. It increments in every cycle the requester is eligible but not granted, and saturates at STARVE_LIM.
  - The counter clears on that requester's grant or when its valid drops.
  - A requester whose counter is at STARVE_LIM outranks wt. If both are saturated, wmb wins.
- Not defined: counters are absent and arbitration is pure wt > wmb > wgs.

## Test plan
- Reset, then all three valid with size 0 and prdy=1 → grants wt every cycle; src=0 appears one cycle after each handshake; credit_cnt stays at 128 when credit_ret is held at 1.
- Credit exhaustion: wt requests size 63 twice, no credit_ret → credit_cnt goes 128→64→0; a third request stalls with ready=0; four credit_ret pulses → credit_cnt=4; a size-3 wmb request is then granted.
- Back-pressure: prdy=0 for 5 cycles with wt valid → pvld holds, pd unchanged, wt_req_ready=0; prdy=1 → accept next cycle.
- Starvation guard (macro on, STARVE_LIM=16): wt and wgs valid continuously → wgs is granted after 16 wt grants; with the macro off, wgs is never granted while wt stays valid.
- Mid-operation reset: pvld=1 and credit_cnt=40, assert rstn=0 for 1 cycle → pvld=0, credit_cnt=128, sched_idle=1 on the next cycle.
